// File: rtl/spio_uart_rx_byte.sv
// spio_uart_rx_byte: oversampling 8N1 UART receiver producing single-cycle byte pulses.
// Optional build macro SPIO_UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample
// point, deciding one cycle later than the single-sample build.
module spio_uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       RX_IN,
  output logic [7:0] BYTE_DATA_OUT,
  output logic       BYTE_VLD_OUT,
  output logic       FRAMING_ERROR_OUT
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned Half = CLKS_PER_BIT / 2;
`ifdef SPIO_UART_RX_MAJORITY_EN
  localparam int unsigned MajDelay = 1;
`else
  localparam int unsigned MajDelay = 0;
`endif

  // Decision points; the start decision slips by the majority delay so that every later
  // decision (which still wraps at CLKS_PER_BIT-1) keeps the same one-cycle offset.
  localparam logic [CntW-1:0] StartDec = CntW'(Half - 1 + MajDelay);
  localparam logic [CntW-1:0] BitDec   = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } state_e;

  logic            rx_meta;
  logic            rx_s;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      shift_q;
  logic            sample;

  // Two-flop synchroniser; resets high so reset never looks like a start edge.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

`ifdef SPIO_UART_RX_MAJORITY_EN
  localparam logic [CntW-1:0] StartM2 = CntW'(Half + MajDelay - 3);
  localparam logic [CntW-1:0] StartM1 = CntW'(Half + MajDelay - 2);
  localparam logic [CntW-1:0] BitM2   = CntW'(CLKS_PER_BIT - 3);
  localparam logic [CntW-1:0] BitM1   = CntW'(CLKS_PER_BIT - 2);

  logic [1:0]      maj_q;
  logic [CntW-1:0] pt_m2;
  logic [CntW-1:0] pt_m1;

  // Pick the two early-sample counts for the current state.
  always_comb begin
    pt_m2 = BitM2;
    pt_m1 = BitM1;
    if (state_q == StStart) begin
      pt_m2 = StartM2;
      pt_m1 = StartM1;
    end
  end

  // Capture the two samples preceding the decision cycle.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      maj_q <= 2'b11;
    end else begin
      if (cnt_q == pt_m2) maj_q[0] <= rx_s;
      if (cnt_q == pt_m1) maj_q[1] <= rx_s;
    end
  end

  // 2-of-3 vote with the live sample taken at the decision cycle.
  always_comb begin
    sample = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
  end
`else
  // Single sample at the decision point.
  always_comb begin
    sample = rx_s;
  end
`endif

  // Frame FSM with registered byte/valid/error outputs.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q           <= StIdle;
      cnt_q             <= '0;
      idx_q             <= 3'd0;
      shift_q           <= 8'h00;
      BYTE_DATA_OUT     <= 8'h00;
      BYTE_VLD_OUT      <= 1'b0;
      FRAMING_ERROR_OUT <= 1'b0;
    end else begin
      BYTE_VLD_OUT      <= 1'b0;
      FRAMING_ERROR_OUT <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          if (cnt_q == StartDec) begin
            cnt_q <= '0;
            if (!sample) begin
              state_q <= StData;
              idx_q   <= 3'd0;
            end else begin
              // Start bit did not hold to mid-bit: glitch, drop silently.
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (cnt_q == BitDec) begin
            cnt_q   <= '0;
            shift_q <= {sample, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (cnt_q == BitDec) begin
            cnt_q <= '0;
            // Leave at mid-stop so a start bit straight after the stop bit is caught.
            if (sample) begin
              BYTE_DATA_OUT <= shift_q;
              BYTE_VLD_OUT  <= 1'b1;
              state_q       <= StIdle;
            end else begin
              FRAMING_ERROR_OUT <= 1'b1;
              state_q           <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBreak: begin
          cnt_q <= '0;
          if (rx_s) state_q <= StIdle;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spio_uart_rx_byte.sv
// Scoreboard bench for spio_uart_rx_byte: stimulus pushes expected pulses, a negedge
// monitor pops and compares each pulse the receiver presents.
module tb_spio_uart_rx_byte;

  localparam int unsigned Cpb = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] byte_data;
  logic       byte_vld;
  logic       ferr;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vld_times[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cycle    = 0;
  logic vld_prev = 1'b0;

  always #5 clk = ~clk;

  spio_uart_rx_byte #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .CLK_IN           (clk),
    .RESET_IN         (rst),
    .RX_IN            (rx),
    .BYTE_DATA_OUT    (byte_data),
    .BYTE_VLD_OUT     (byte_vld),
    .FRAMING_ERROR_OUT(ferr)
  );

  always @(posedge clk) cycle++;

  // Monitor: pop and compare on every presented pulse.
  always @(negedge clk) begin
    exp_t e;
    if (byte_vld) begin
      checks++;
      if (vld_prev) begin
        errors++;
        $display("FAIL vld_consecutive: got vld high two cycles in a row, want isolated pulse");
      end
      vld_times.push_back(cycle);
    end
    if (byte_vld && ferr) begin
      checks++;
      errors++;
      $display("FAIL vld_and_err: got both high, want never together");
    end
    if (byte_vld || ferr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got vld=%0b err=%0b data=%h, want none", byte_vld, ferr,
                 byte_data);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err != ferr || (!e.is_err && e.data != byte_data)) begin
          errors++;
          $display("FAIL pulse: got err=%0b data=%h, want err=%0b data=%h", ferr, byte_data,
                   e.is_err, e.data);
        end
      end
    end
    vld_prev = byte_vld;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive ncyc cycles of an 8N1 frame; glitch_at inverts the line for that one cycle.
  task automatic send_frame(input logic [7:0] b, input int glitch_at, input int ncyc);
    logic v;
    int   bi;
    for (int c = 0; c < ncyc; c++) begin
      bi = c / Cpb;
      if (bi == 0) v = 1'b0;
      else if (bi >= 9) v = 1'b1;
      else v = b[bi-1];
      if (c == glitch_at) v = ~v;
      rx = v;
      @(negedge clk);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int diff;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data", byte_data, 8'h00);
    chk("reset_vld", {7'd0, byte_vld}, 8'h00);
    chk("reset_err", {7'd0, ferr}, 8'h00);
    rst = 1'b0;
    idle(8);

    // Single clean frame.
    exp_byte(8'hA5);
    send_frame(8'hA5, -1, 10 * Cpb);
    idle(20);

    // Back-to-back frames, stop bit directly followed by start bit.
    n0 = vld_times.size();
    exp_byte(8'h00);
    exp_byte(8'hFF);
    send_frame(8'h00, -1, 10 * Cpb);
    send_frame(8'hFF, -1, 10 * Cpb);
    idle(20);
    checks++;
    if (vld_times.size() < n0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, want 2", vld_times.size() - n0);
    end else begin
      diff = vld_times[n0+1] - vld_times[n0];
      if (diff < 159 || diff > 161) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles, want 160+-1", diff);
      end
    end

    // Short low glitch on idle line, then a real frame.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(40);
    exp_byte(8'h3C);
    send_frame(8'h3C, -1, 10 * Cpb);
    idle(20);

    // Line break of 20 bit times: one error pulse, then recovery.
    exp_err();
    rx = 1'b0;
    repeat (20 * Cpb) @(negedge clk);
    idle(32);
    exp_byte(8'h81);
    send_frame(8'h81, -1, 10 * Cpb);
    idle(20);

    // Reset pulse in the middle of data bit 4 aborts the frame silently.
    send_frame(8'h33, -1, 5 * Cpb + 8);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_vld", {7'd0, byte_vld}, 8'h00);
    chk("midreset_err", {7'd0, ferr}, 8'h00);
    idle(40);
    exp_byte(8'h5A);
    send_frame(8'h5A, -1, 10 * Cpb);
    idle(20);

    // One-cycle inversion at the centre of data bit 2.
`ifdef SPIO_UART_RX_MAJORITY_EN
    exp_byte(8'hF0);
`else
    exp_byte(8'hF4);
`endif
    send_frame(8'hF0, 3 * Cpb + 8, 10 * Cpb);
    idle(40);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got %0d expected pulses never seen, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spio_uart_rx_byte.md
Name: spio_uart_rx_byte

Overview:
Bit-level UART receiver; the stage directly upstream of the packet-assembly receive control.
- Oversamples the asynchronous serial line RX_IN and recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Emits each byte as a single-cycle BYTE_VLD_OUT pulse with no ready signal.
- Frame length guarantees at least 10*CLKS_PER_BIT cycles between pulses, so valid is never asserted in consecutive cycles, as the downstream stage requires.

Parameters:
CLKS_PER_BIT, 16, CLK_IN cycles per serial bit; legal range 4..65535.

Ports:
CLK_IN  input  1  common clock.
RESET_IN  input  1  synchronous, active-high reset.
RX_IN  input  1  asynchronous serial line; idles high.
BYTE_DATA_OUT  output  8  last received byte; valid only while BYTE_VLD_OUT is high.
BYTE_VLD_OUT  output  1  single-cycle pulse per good frame.
FRAMING_ERROR_OUT  output  1  single-cycle pulse when the stop bit samples low.

Behaviour:
- Reset: synchronous, active-high, on the CLK_IN edge. Values after reset:
  - BYTE_DATA_OUT=8'h00, BYTE_VLD_OUT=0, FRAMING_ERROR_OUT=0.
  - State IDLE, bit counter and bit index 0.
  - Both synchroniser flops =1, so reset does not fake a start edge.
- Input path: 2-flop synchroniser RX_IN -> rx_s. All decisions use rx_s only.
- Cycle counter cnt: width clog2(CLKS_PER_BIT). Cleared on every state entry. H = CLKS_PER_BIT/2 (floor).
- IDLE: rx_s==0 -> START.
- START: at cnt==H-1 sample rx_s.
  - 0 -> DATA with bit index 0.
  - 1 -> IDLE. Treated as a glitch: no error pulse.
- DATA: at cnt==CLKS_PER_BIT-1 sample rx_s and shift it into shift[7] (right shift, LSB first); cnt resets to 0.
  - After the 8th sample -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1 sample rx_s.
  - 1 -> next cycle BYTE_DATA_OUT=shift and BYTE_VLD_OUT=1 for exactly one cycle; state -> IDLE.
  - 0 -> next cycle FRAMING_ERROR_OUT=1 for one cycle; no vld; state -> BREAK.
- BREAK: wait for rx_s==1, then IDLE. Covers line-break or stuck-low conditions; exactly one error pulse per break.
- Mid-stop resynchronisation: STOP returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- Latency: vld rises 2 (synchroniser) + 1 cycles after the mid-stop-bit line value.
- BYTE_VLD_OUT and FRAMING_ERROR_OUT are never asserted together.
- Illegal or unused state encoding -> IDLE on the next cycle.
- Reset mid-frame: the partial byte is discarded and no pulse is emitted. After release, a line held low is treated as a new start edge.

Optional Feature:
Macro SPIO_UART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, stop) takes rx_s at cnt==P-1, P and P+1, where P is the nominal sample count. The 2-of-3 majority is used.
  - The decision is made at P+1, adding 1 cycle of latency.
  - CLKS_PER_BIT must be >=4.
  - cnt for DATA/STOP still wraps at CLKS_PER_BIT-1, offset so bit spacing is unchanged.
- Undefined: single sample at P, exactly as above. Majority logic is not instantiated.

Test Plan:
1. CLKS_PER_BIT=16; drive frame 0xA5 at exactly 16 cycles/bit -> exactly one BYTE_VLD_OUT pulse, BYTE_DATA_OUT=8'hA5, no FRAMING_ERROR_OUT.
2. Frames 0x00 then 0xFF back-to-back (stop bit immediately followed by start bit) -> two vld pulses carrying 8'h00 then 8'hFF, separated by 160±1 cycles; never consecutive.
3. 4-cycle low glitch on an idle line -> no vld, no error; a following 0x3C frame is received correctly.
4. Hold line low for 20 bit periods, then high, then send 0x81 -> exactly one FRAMING_ERROR_OUT pulse, no vld for the break, then vld with 8'h81.
5. Assert RESET_IN for 1 cycle during data bit 4 of a frame; line idles high afterwards -> no vld or error from the aborted frame; the next frame 0x5A is received correctly.
6. With SPIO_UART_RX_MAJORITY_EN defined, send 0xF0 with a 1-cycle inverted pulse exactly at mid-bit of data bit 2 -> vld with 8'hF0. Without the macro, the same stimulus yields 8'hF4.
